// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, ALUop encodings and exec FSM states
package alu_pkg;

    // Decoded 4-bit ALU operations
    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SLL     = 4'b0011;
    localparam logic [3:0] OP_XOR     = 4'b0100;
    localparam logic [3:0] OP_SRL     = 4'b0101;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_SRA     = 4'b0111;
    localparam logic [3:0] OP_SLT     = 4'b1000;
    localparam logic [3:0] OP_SLTU    = 4'b1001;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    // ALUop field from the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUop/funct decode; SLT/SLTU gated by ALU_SLT_EN
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] operation,
    output logic       illegal
);

    // Map ALUop/funct3/funct7[5] onto an ALU operation; I-type never subtracts
    always_comb begin
        operation = OP_ADD;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_MEM:    operation = OP_ADD;
            ALUOP_BRANCH: operation = OP_SUB;
            default: begin
                case (funct3)
                    3'b000: operation = (funct7_5 && (alu_op == ALUOP_RTYPE)) ? OP_SUB : OP_ADD;
                    3'b001: operation = OP_SLL;
`ifdef ALU_SLT_EN
                    3'b010: operation = OP_SLT;
                    3'b011: operation = OP_SLTU;
`else
                    3'b010: begin
                        operation = OP_ILLEGAL;
                        illegal   = 1'b1;
                    end
                    3'b011: begin
                        operation = OP_ILLEGAL;
                        illegal   = 1'b1;
                    end
`endif
                    3'b100: operation = OP_XOR;
                    3'b101: operation = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110: operation = OP_OR;
                    3'b111: operation = OP_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_exec.sv
// rtl/alu_ctrl_exec.sv - handshaked ALU with iterative shifter; ALU_SLT_EN enables SLT/SLTU
module alu_ctrl_exec
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
)
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      operation,
    output logic            illegal
);

    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [SHAMT_W:0] STEP_MAX = (SHAMT_W+1)'(SHIFT_STEP);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         w_dec_op;
    logic               w_dec_illegal;
    logic [XLEN-1:0]    w_exec;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic               w_start_shift;
    logic               w_accept;
    logic               w_last_step;
    logic [SHAMT_W:0]   w_step;
    logic [XLEN-1:0]    w_shifted;

    // Shift working set; the visible result registers only change on completion
    logic [XLEN-1:0]    r_work;
    logic [SHAMT_W-1:0] r_remain;
    logic [3:0]         r_shift_op;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic [3:0]         r_operation;
    logic               r_illegal;

    alu_op_decode u_decode (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .operation (w_dec_op),
        .illegal   (w_dec_illegal)
    );

    assign w_shamt       = operand_b[SHAMT_W-1:0];
    assign w_is_shift    = (w_dec_op == OP_SLL) || (w_dec_op == OP_SRL) || (w_dec_op == OP_SRA);
    assign w_start_shift = w_is_shift && (w_shamt != '0);
    assign in_ready      = ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready)) && !flush;
    assign w_accept      = in_valid && in_ready;
    assign out_valid     = (r_state == ST_DONE) && !flush;
    assign w_last_step   = ({1'b0, r_remain} <= STEP_MAX);
    assign w_step        = w_last_step ? {1'b0, r_remain} : STEP_MAX;

    assign result    = r_result;
    assign zero      = r_zero;
    assign operation = r_operation;
    assign illegal   = r_illegal;

    // Single-cycle result; shifts by zero pass operand_a through, illegal yields 0
    always_comb begin
        w_exec = '0;
        case (w_dec_op)
            OP_ADD:  w_exec = operand_a + operand_b;
            OP_SUB:  w_exec = operand_a - operand_b;
            OP_AND:  w_exec = operand_a & operand_b;
            OP_OR:   w_exec = operand_a | operand_b;
            OP_XOR:  w_exec = operand_a ^ operand_b;
            OP_SLL,
            OP_SRL,
            OP_SRA:  w_exec = operand_a;
`ifdef ALU_SLT_EN
            OP_SLT:  w_exec = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: w_exec = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
`endif
            default: w_exec = '0;
        endcase
    end

    // One shifter step of at most SHIFT_STEP bits
    always_comb begin
        w_shifted = r_work >> w_step;
        case (r_shift_op)
            OP_SLL:  w_shifted = r_work << w_step;
            OP_SRA:  w_shifted = $signed(r_work) >>> w_step;
            default: w_shifted = r_work >> w_step;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: flush wins, DONE can pop and accept in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_state_nxt = w_start_shift ? ST_SHIFT : ST_DONE;
                end
                ST_SHIFT: begin
                    if (w_last_step) w_state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (w_accept)       w_state_nxt = w_start_shift ? ST_SHIFT : ST_DONE;
                    else if (out_ready) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Latch on accept, advance the shifter, publish result fields on completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_work      <= '0;
            r_remain    <= '0;
            r_shift_op  <= OP_SLL;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_operation <= OP_ADD;
            r_illegal   <= 1'b0;
        end else if (!flush) begin
            if (w_accept) begin
                if (w_start_shift) begin
                    r_work     <= operand_a;
                    r_remain   <= w_shamt;
                    r_shift_op <= w_dec_op;
                end else begin
                    r_result    <= w_exec;
                    r_zero      <= (w_exec == '0);
                    r_operation <= w_dec_op;
                    r_illegal   <= w_dec_illegal;
                end
            end else if (r_state == ST_SHIFT) begin
                r_work   <= w_shifted;
                r_remain <= r_remain - w_step[SHAMT_W-1:0];
                if (w_last_step) begin
                    r_result    <= w_shifted;
                    r_zero      <= (w_shifted == '0);
                    r_operation <= r_shift_op;
                    r_illegal   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// tb/tb_alu_ctrl_exec.sv - directed vector bench for alu_ctrl_exec
module tb_alu_ctrl_exec;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [3:0]  operation;
    logic        illegal;

    int n_checks = 0;
    int n_err    = 0;

    alu_ctrl_exec #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .operation (operation),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  oper;
        logic        ill;
        logic        zr;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        alu_op    = op;
        funct3    = f3;
        funct7_5  = f7;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        @(negedge clock);
        in_valid  = 1'b0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int hi;

        vecs[0]  = '{2'b10, 3'b000, 1'b1, 32'd5,        32'd7,        32'hFFFFFFFE, 4'b0110, 1'b0, 1'b0, 1};
        vecs[1]  = '{2'b01, 3'b111, 1'b0, 32'h1234,     32'h1234,     32'h0,        4'b0110, 1'b0, 1'b1, 1};
        vecs[2]  = '{2'b10, 3'b101, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 4'b0111, 1'b0, 1'b0, 5};
        vecs[3]  = '{2'b00, 3'b110, 1'b1, 32'd10,       32'd20,       32'd30,       4'b0010, 1'b0, 1'b0, 1};
        vecs[4]  = '{2'b11, 3'b000, 1'b1, 32'd5,        32'd7,        32'd12,       4'b0010, 1'b0, 1'b0, 1};
        vecs[5]  = '{2'b10, 3'b001, 1'b0, 32'd1,        32'd31,       32'h80000000, 4'b0011, 1'b0, 1'b0, 32};
        vecs[6]  = '{2'b10, 3'b101, 1'b0, 32'h80000000, 32'h24,       32'h08000000, 4'b0101, 1'b0, 1'b0, 5};
        vecs[7]  = '{2'b10, 3'b100, 1'b0, 32'hF0F0,     32'h0FF0,     32'hFF00,     4'b0100, 1'b0, 1'b0, 1};
        vecs[8]  = '{2'b11, 3'b110, 1'b0, 32'hF0F0,     32'h0FF0,     32'hFFF0,     4'b0001, 1'b0, 1'b0, 1};
        vecs[9]  = '{2'b10, 3'b111, 1'b0, 32'hF0F0,     32'h0FF0,     32'h00F0,     4'b0000, 1'b0, 1'b0, 1};
        vecs[10] = '{2'b10, 3'b101, 1'b1, 32'h80000000, 32'h0,        32'h80000000, 4'b0111, 1'b0, 1'b0, 1};
`ifdef ALU_SLT_EN
        vecs[11] = '{2'b10, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b1000, 1'b0, 1'b0, 1};
        vecs[12] = '{2'b10, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1001, 1'b0, 1'b1, 1};
`else
        vecs[11] = '{2'b10, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1111, 1'b1, 1'b1, 1};
        vecs[12] = '{2'b11, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1111, 1'b1, 1'b1, 1};
`endif
        vecs[13] = '{2'b00, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0010, 1'b0, 1'b1, 1};

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        funct3    = 3'b000;
        funct7_5  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(negedge clock);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    result,              32'd0);
        check("rst_zero",      {31'd0, zero},       32'd0);
        check("rst_operation", {28'd0, operation},  32'd2);
        check("rst_illegal",   {31'd0, illegal},    32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            wait_result(cyc);
            check($sformatf("v%0d_latency", i),   cyc,                        vecs[i].lat);
            check($sformatf("v%0d_result", i),    result,                     vecs[i].res);
            check($sformatf("v%0d_operation", i), {28'd0, operation},         {28'd0, vecs[i].oper});
            check($sformatf("v%0d_zero", i),      {31'd0, zero},              {31'd0, vecs[i].zr});
            check($sformatf("v%0d_illegal", i),   {31'd0, illegal},           {31'd0, vecs[i].ill});
            pop();
        end

        // Backpressure then pop-and-accept in the same edge
        issue(2'b00, 3'b000, 1'b0, 32'd3, 32'd4);
        wait_result(cyc);
        check("bp_latency", cyc, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("bp_hold_result",  result,              32'd7);
            check("bp_hold_valid",   {31'd0, out_valid},  32'd1);
            check("bp_hold_inready", {31'd0, in_ready},   32'd0);
        end
        out_ready = 1'b1;
        operand_a = 32'd1;
        operand_b = 32'd1;
        in_valid  = 1'b1;
        #1;
        check("b2b_inready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_result",    result,             32'd2);
        pop();

        // Flush in the middle of a long shift
        issue(2'b10, 3'b001, 1'b0, 32'd1, 32'd20);
        repeat (2) @(negedge clock);
        check("shift_inready", {31'd0, in_ready},  32'd0);
        check("shift_valid",   {31'd0, out_valid}, 32'd0);
        flush = 1'b1;
        #1;
        check("flush_inready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        flush = 1'b0;
        #1;
        check("post_flush_inready", {31'd0, in_ready},  32'd1);
        check("post_flush_valid",   {31'd0, out_valid}, 32'd0);
        check("post_flush_result",  result,             32'd2);
        hi = 0;
        repeat (25) begin
            @(negedge clock);
            if (out_valid) hi++;
        end
        check("flushed_op_never_valid", hi, 0);
        issue(2'b00, 3'b000, 1'b0, 32'd6, 32'd7);
        wait_result(cyc);
        check("post_flush_add_latency", cyc,    1);
        check("post_flush_add_result",  result, 32'd13);
        pop();

        // Asynchronous reset while shifting
        issue(2'b10, 3'b101, 1'b1, 32'h80000000, 32'd10);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid",     {31'd0, out_valid}, 32'd0);
        check("rst_mid_result",    result,             32'd0);
        check("rst_mid_operation", {28'd0, operation}, 32'd2);
        check("rst_mid_inready",   {31'd0, in_ready},  32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        issue(2'b00, 3'b000, 1'b0, 32'd2, 32'd2);
        wait_result(cyc);
        check("post_rst_latency", cyc,    1);
        check("post_rst_result",  result, 32'd4);
        pop();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
